// File: rtl/mips_pc_pkg.sv
// Shared types and constants for the fetch PC sequencer.
package mips_pc_pkg;

    // Sequencer FSM: normal fetch, or a redirect latched while fetch was stalled.
    typedef enum logic {
        RUN,
        HOLD_REDIR
    } seq_state_t;

    // Where a redirect came from; ordering reflects pipeline age (EX oldest).
    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_JUMP,
        SRC_JR,
        SRC_BRANCH
    } redir_src_t;

    localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-redirect bus between the core pipeline (master) and the PC sequencer (slave).
interface pc_sequencer_if #(
    parameter int PC_W = 32
);
    logic            stall;
    logic            jump_flag;
    logic [25:0]     jump_offset;
    logic            jr_flag;
    logic [PC_W-1:0] jr_target;
    logic            branch_taken;
    logic [PC_W-1:0] branch_target;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] next_pc;
    logic            flush;
    logic            redirect_pending;

    modport master (
        output stall, jump_flag, jump_offset, jr_flag, jr_target,
               branch_taken, branch_target,
        input  pc, next_pc, flush, redirect_pending
    );

    modport slave (
        input  stall, jump_flag, jump_offset, jr_flag, jr_target,
               branch_taken, branch_target,
        output pc, next_pc, flush, redirect_pending
    );
endinterface

// File: rtl/pc_target_mux.sv
// Combinational redirect arbiter: picks the oldest redirect request and forms
// its word-aligned target. With no request the target is the sequential PC.
module pc_target_mux
    import mips_pc_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic [PC_W-1:0] next_pc,
    input  logic            jump_flag,
    input  logic [25:0]     jump_offset,
    input  logic            jr_flag,
    input  logic [PC_W-1:0] jr_target,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic [PC_W-1:0] target,
    output redir_src_t      src
);

    // Priority select: EX branch beats ID jump-register beats ID jump.
    always_comb begin
        target = next_pc;
        src    = SRC_NONE;
        if (branch_taken) begin
            target = {branch_target[PC_W-1:2], 2'b00};
            src    = SRC_BRANCH;
        end else if (jr_flag) begin
            target = {jr_target[PC_W-1:2], 2'b00};
            src    = SRC_JR;
        end else if (jump_flag) begin
            // J-type region comes from the delay-slot PC (pc+4), not pc.
            target = {next_pc[PC_W-1:28], jump_offset, 2'b00};
            src    = SRC_JUMP;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch program counter owner. Applies redirects immediately when fetch is
// free, or parks one redirect while fetch is stalled and applies it on release.
module pc_sequencer
    import mips_pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_W     = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_sequencer_if.slave bus
);

    seq_state_t      state_reg, state_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic [PC_W-1:0] pend_target_reg, pend_target_next;
    redir_src_t      pend_src_reg, pend_src_next;
    logic            flush_reg, flush_next;

    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] mux_target;
    redir_src_t      mux_src;
    logic            br_override;

    assign seq_pc = pc_reg + PC_W'(PC_INC);

    pc_target_mux #(.PC_W(PC_W)) u_mux (
        .next_pc       (seq_pc),
        .jump_flag     (bus.jump_flag),
        .jump_offset   (bus.jump_offset),
        .jr_flag       (bus.jr_flag),
        .jr_target     (bus.jr_target),
        .branch_taken  (bus.branch_taken),
        .branch_target (bus.branch_target),
        .target        (mux_target),
        .src           (mux_src)
    );

    // A branch in EX is older than any parked ID redirect, so it may replace it;
    // a second branch behind a parked branch is wrong-path.
    assign br_override = (mux_src == SRC_BRANCH) && (pend_src_reg != SRC_BRANCH);

    // State, PC, pending redirect and flush registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= RUN;
            pc_reg          <= PC_W'(RESET_PC);
            pend_target_reg <= '0;
            pend_src_reg    <= SRC_NONE;
            flush_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            pend_target_reg <= pend_target_next;
            pend_src_reg    <= pend_src_next;
            flush_reg       <= flush_next;
        end
    end

    // Next-state, next-PC and flush decisions.
    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        pend_target_next = pend_target_reg;
        pend_src_next    = pend_src_reg;
        flush_next       = 1'b0;
        case (state_reg)
            RUN: begin
                if (mux_src != SRC_NONE) begin
                    flush_next = 1'b1;
                    if (!bus.stall) begin
                        pc_next = mux_target;
                    end else begin
                        pend_target_next = mux_target;
                        pend_src_next    = mux_src;
                        state_next       = HOLD_REDIR;
                    end
                end else if (!bus.stall) begin
                    pc_next = seq_pc;
                end
            end
            HOLD_REDIR: begin
                if (bus.stall) begin
                    if (br_override) begin
                        pend_target_next = mux_target;
                        pend_src_next    = SRC_BRANCH;
                        flush_next       = 1'b1;
                    end
                end else begin
                    // The squash already happened when the redirect was parked.
                    pc_next          = br_override ? mux_target : pend_target_reg;
                    pend_target_next = '0;
                    pend_src_next    = SRC_NONE;
                    state_next       = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    assign bus.pc               = pc_reg;
    assign bus.next_pc          = seq_pc;
    assign bus.flush            = flush_reg;
    assign bus.redirect_pending = (state_reg == HOLD_REDIR);

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed stimulus pushes hand-computed
// expectations; a monitor pops and compares after every clock edge.
module tb_pc_sequencer;

    logic clk;
    logic rst_n;

    pc_sequencer_if #(.PC_W(32)) bus ();

    pc_sequencer #(.RESET_PC(32'h0000_0000), .PC_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        fl;
        logic        pd;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    event async_ev;

    function automatic void check(string name, logic [31:0] got, logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endfunction

    // Monitor: every edge (or asynchronous event) the DUT presents a new state.
    initial begin
        forever begin
            @(posedge clk or async_ev);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                logic [31:0] want_npc;
                e = q.pop_front();
                want_npc = e.pc + 32'd4;
                check({e.tag, ".pc"}, bus.pc, e.pc);
                check({e.tag, ".next_pc"}, bus.next_pc, want_npc);
                check({e.tag, ".flush"}, {31'd0, bus.flush}, {31'd0, e.fl});
                check({e.tag, ".pending"}, {31'd0, bus.redirect_pending}, {31'd0, e.pd});
                $display("txn %-10s pc=%h flush=%0b pend=%0b", e.tag, bus.pc, bus.flush,
                         bus.redirect_pending);
            end
        end
    end

    task automatic cyc(input logic st, input logic jf, input logic [25:0] jo,
                       input logic jrf, input logic [31:0] jrt,
                       input logic bt, input logic [31:0] btg,
                       input logic [31:0] epc, input logic efl, input logic epd,
                       input string tag);
        exp_t e;
        @(negedge clk);
        bus.stall         = st;
        bus.jump_flag     = jf;
        bus.jump_offset   = jo;
        bus.jr_flag       = jrf;
        bus.jr_target     = jrt;
        bus.branch_taken  = bt;
        bus.branch_target = btg;
        e.pc = epc; e.fl = efl; e.pd = epd; e.tag = tag;
        q.push_back(e);
    endtask

    task automatic idle(input logic [31:0] epc, input string tag);
        cyc(0, 0, 26'h0, 0, 32'h0, 0, 32'h0, epc, 0, 0, tag);
    endtask

    task automatic hold(input logic [31:0] epc, input string tag);
        cyc(1, 0, 26'h0, 0, 32'h0, 0, 32'h0, epc, 0, 1, tag);
    endtask

    initial begin
        exp_t e;
        rst_n             = 1'b0;
        bus.stall         = 1'b0;
        bus.jump_flag     = 1'b0;
        bus.jump_offset   = '0;
        bus.jr_flag       = 1'b0;
        bus.jr_target     = '0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;

        // Reset and sequential fetch
        idle(32'h0, "rst");
        @(negedge clk); rst_n = 1'b1;
        e.pc = 32'h4; e.fl = 0; e.pd = 0; e.tag = "seq4"; q.push_back(e);
        idle(32'h8, "seq8");
        idle(32'hC, "seqC");

        // JR back to 0x4, then J with offset 3 from pc=0x4
        cyc(0, 0, 26'h0, 1, 32'h4, 0, 32'h0, 32'h4, 1, 0, "jr4");
        cyc(0, 1, 26'h3, 0, 32'h0, 0, 32'h0, 32'hC, 1, 0, "jump");
        idle(32'h10, "postjmp");

        // All three redirects at once: branch wins
        cyc(0, 1, 26'h3, 1, 32'h200, 1, 32'h100, 32'h100, 1, 0, "simul");
        idle(32'h104, "postsim");

        // Jump parked during stall, applied on release
        cyc(1, 1, 26'h40, 0, 32'h0, 0, 32'h0, 32'h104, 1, 1, "stjmp");
        hold(32'h104, "hold1");
        hold(32'h104, "hold2");
        idle(32'h100, "rel");
        idle(32'h104, "postrel");

        // Parked jump overridden by a branch
        cyc(1, 1, 26'h40, 0, 32'h0, 0, 32'h0, 32'h104, 1, 1, "ovjmp");
        cyc(1, 0, 26'h0, 0, 32'h0, 1, 32'h200, 32'h104, 1, 1, "ovbr");
        hold(32'h104, "ovhold");
        idle(32'h200, "ovrel");
        idle(32'h204, "postov");

        // Parked branch: later jump and branch are wrong-path; jr at release ignored
        cyc(1, 0, 26'h0, 0, 32'h0, 1, 32'h200, 32'h204, 1, 1, "pbr");
        cyc(1, 1, 26'h40, 0, 32'h0, 0, 32'h0, 32'h204, 0, 1, "pbrjmp");
        cyc(1, 0, 26'h0, 0, 32'h0, 1, 32'h300, 32'h204, 0, 1, "pbrbr");
        cyc(0, 0, 26'h0, 1, 32'h500, 0, 32'h0, 32'h200, 0, 0, "pbrrel");
        idle(32'h204, "postpbr");

        // Branch replaces a parked jump in the release cycle itself
        cyc(1, 1, 26'h40, 0, 32'h0, 0, 32'h0, 32'h204, 1, 1, "rjmp");
        cyc(0, 0, 26'h0, 0, 32'h0, 1, 32'h300, 32'h300, 0, 0, "rbrrel");
        idle(32'h304, "postr");

        // Wraparound and target alignment
        cyc(0, 0, 26'h0, 1, 32'hFFFF_FFFC, 0, 32'h0, 32'hFFFF_FFFC, 1, 0, "jrtop");
        idle(32'h0, "wrap");
        cyc(0, 0, 26'h0, 1, 32'h103, 0, 32'h0, 32'h100, 1, 0, "jralign");
        idle(32'h104, "postal");

        // Asynchronous reset while a redirect is parked
        cyc(1, 1, 26'h40, 0, 32'h0, 0, 32'h0, 32'h104, 1, 1, "prst");
        hold(32'h104, "prsthold");
        @(posedge clk); #3;
        rst_n = 1'b0;
        e.pc = 32'h0; e.fl = 0; e.pd = 0; e.tag = "arst"; q.push_back(e);
        -> async_ev;
        idle(32'h0, "arstlow");
        @(negedge clk); rst_n = 1'b1;
        e.pc = 32'h4; e.fl = 0; e.pd = 0; e.tag = "arstrel"; q.push_back(e);
        idle(32'h8, "arstseq");

        // Bounded drain of the scoreboard
        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        #2;
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d entries left want 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
